// File: rtl/tx_manch_frame.sv
// tx_manch_frame -- Manchester frame transmitter.
//
// Sends NBIT data bits MSB first, optionally followed by one even-parity bit.
// Each bit cell is two ce_tact periods: the bit value is driven in the first
// half, its complement in the second half (1 = high-then-low).
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   ce_tact  in   half-bit clock enable (one clk wide)
//   ce_st    in   frame-start enable (one clk wide)
//   din      in   parallel data, bits [NBIT-1:0] used
//   txd      out  Manchester line, idles low
//   en_tx    out  high while a frame is on the line
//   ce_bit   out  pulse at the end of every bit cell
//   done     out  pulse at the end of the frame
//   ovr      out  pulse when a start request is dropped during a frame
module tx_manch_frame #(
  parameter int NBIT = 16,
  parameter int PAR  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_tact,
  input  logic        ce_st,
  input  logic [15:0] din,
  output logic        txd,
  output logic        en_tx,
  output logic        ce_bit,
  output logic        done,
  output logic        ovr
);

  localparam int NCELL = NBIT + PAR;

  typedef enum logic {IDLE, TX} state_t;

  state_t            state_q;
  logic              hf_q;
  logic [4:0]        cb_q;
  logic [NBIT-1:0]   sr_q;
  logic              par_q;
  logic              txd_q, en_tx_q, ce_bit_q, done_q, ovr_q;

  logic cur_bit, nxt_bit, par_nx, last_cell;

  // Data cells come from the MSB of sr; the trailing cell (if any) is parity.
  assign cur_bit   = (cb_q < 5'(NBIT)) ? sr_q[NBIT-1] : par_q;
  assign par_nx    = par_q ^ cur_bit;
  // Bit that follows the current one: next data bit, or the finished parity.
  assign nxt_bit   = (cb_q < 5'(NBIT-1)) ? sr_q[NBIT-2] : par_nx;
  assign last_cell = (cb_q == 5'(NCELL-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hf_q     <= 1'b0;
      cb_q     <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b0;
      en_tx_q  <= 1'b0;
      ce_bit_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ce_bit_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ce_st) begin
            sr_q    <= din[NBIT-1:0];
            state_q <= TX;
            hf_q    <= 1'b0;
            cb_q    <= '0;
            par_q   <= 1'b0;
            en_tx_q <= 1'b1;
            txd_q   <= din[NBIT-1];
          end
        end
        TX: begin
          if (ce_tact && !hf_q) begin
            hf_q  <= 1'b1;
            txd_q <= ~cur_bit;
            if (ce_st) ovr_q <= 1'b1;
          end else if (ce_tact) begin
            hf_q     <= 1'b0;
            ce_bit_q <= 1'b1;
            par_q    <= par_nx;
            cb_q     <= cb_q + 5'd1;
            sr_q     <= sr_q << 1;
            txd_q    <= nxt_bit;
            if (last_cell) begin
              done_q <= 1'b1;
              if (ce_st) begin
                // Start on the closing edge: chain the next frame with no gap.
                sr_q    <= din[NBIT-1:0];
                cb_q    <= '0;
                par_q   <= 1'b0;
                txd_q   <= din[NBIT-1];
              end else begin
                state_q <= IDLE;
                cb_q    <= '0;
                txd_q   <= 1'b0;
                en_tx_q <= 1'b0;
              end
            end else if (ce_st) begin
              ovr_q <= 1'b1;
            end
          end else if (ce_st) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd    = txd_q;
  assign en_tx  = en_tx_q;
  assign ce_bit = ce_bit_q;
  assign done   = done_q;
  assign ovr    = ovr_q;

  // Upper data bits are intentionally ignored.
  if (NBIT < 16) begin : g_unused
    logic unused_din;
    assign unused_din = ^din[15:NBIT];
  end

endmodule

// File: tb/tb_tx_manch_frame.sv
// Bench for tx_manch_frame: DUT A (NBIT=16, PAR=1) and DUT B (NBIT=4, PAR=0)
// share clock, reset and ce_tact, each with its own start and data.
// The reference model turns an accepted word into its list of half-cell
// line levels and walks that list one entry per ce_tact.
module tb_tx_manch_frame;

  logic        clk = 0, rst = 1, ce_tact = 0, ce_st_a = 0, ce_st_b = 0;
  logic [15:0] din_a = 0, din_b = 0;
  logic        txd_a, en_a, ceb_a, done_a, ovr_a;
  logic        txd_b, en_b, ceb_b, done_b, ovr_b;

  int nchk = 0, npass = 0;

  tx_manch_frame #(.NBIT(16), .PAR(1)) dut_a (
    .clk(clk), .rst(rst), .ce_tact(ce_tact), .ce_st(ce_st_a), .din(din_a),
    .txd(txd_a), .en_tx(en_a), .ce_bit(ceb_a), .done(done_a), .ovr(ovr_a));

  tx_manch_frame #(.NBIT(4), .PAR(0)) dut_b (
    .clk(clk), .rst(rst), .ce_tact(ce_tact), .ce_st(ce_st_b), .din(din_b),
    .txd(txd_b), .en_tx(en_b), .ce_bit(ceb_b), .done(done_b), .ovr(ovr_b));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit seq [2][34];
  int len [2];
  int pos [2];
  bit e_txd [2], e_en [2], e_ceb [2], e_done [2], e_ovr [2];

  task automatic load(input int k);
    int nb, pb, ones;
    logic [15:0] d;
    nb = (k == 0) ? 16 : 4;
    pb = (k == 0) ? 1 : 0;
    d  = (k == 0) ? din_a : din_b;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      seq[k][2*i]   = d[nb-1-i];
      seq[k][2*i+1] = ~d[nb-1-i];
      ones += int'(d[nb-1-i]);
    end
    if (pb == 1) begin
      seq[k][2*nb]   = bit'(ones % 2);
      seq[k][2*nb+1] = ~bit'(ones % 2);
    end
    len[k] = 2 * (nb + pb);
    pos[k] = 0;
  endtask

  task automatic mdl(input int k, input bit t, input bit s);
    int rem;
    rem = len[k] - pos[k];
    e_ceb[k] = 0; e_done[k] = 0; e_ovr[k] = 0;
    if (rst) begin
      len[k] = 0; pos[k] = 0;
    end else if (rem > 0 && t) begin
      pos[k]++;
      rem--;
      if (rem % 2 == 0) e_ceb[k] = 1;
      if (rem == 0) begin
        e_done[k] = 1;
        if (s) load(k);
      end else if (s) e_ovr[k] = 1;
    end else if (rem > 0 && s) begin
      e_ovr[k] = 1;
    end else if (rem == 0 && s) begin
      load(k);
    end
    rem = len[k] - pos[k];
    e_en[k]  = (rem > 0);
    e_txd[k] = (rem > 0) ? seq[k][pos[k]] : 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string w);
    chk({w, " A txd"},   64'(txd_a), 64'(e_txd[0]));
    chk({w, " A en_tx"}, 64'(en_a),  64'(e_en[0]));
    chk({w, " A ce_bit"},64'(ceb_a), 64'(e_ceb[0]));
    chk({w, " A done"},  64'(done_a),64'(e_done[0]));
    chk({w, " A ovr"},   64'(ovr_a), 64'(e_ovr[0]));
    chk({w, " B txd"},   64'(txd_b), 64'(e_txd[1]));
    chk({w, " B en_tx"}, 64'(en_b),  64'(e_en[1]));
    chk({w, " B ce_bit"},64'(ceb_b), 64'(e_ceb[1]));
    chk({w, " B done"},  64'(done_b),64'(e_done[1]));
    chk({w, " B ovr"},   64'(ovr_b), 64'(e_ovr[1]));
  endtask

  // One clock: drive, edge, update model, sample 1 ns later.
  task automatic step(input bit t, input bit sa, input bit sb, input string w);
    ce_tact = t; ce_st_a = sa; ce_st_b = sb;
    @(posedge clk);
    mdl(0, t, sa);
    mdl(1, t, sb);
    #1;
    chk_all(w);
    ce_tact = 0; ce_st_a = 0; ce_st_b = 0;
  endtask

  // One half-cell period: 3 quiet clocks then a ce_tact clock.
  task automatic half(input bit sa, input bit sb, input string w);
    repeat (3) step(0, 0, 0, w);
    step(1, sa, sb, w);
  endtask

  logic [33:0] tr_a;
  logic [15:0] tr_b;
  int nceb, novr;

  initial begin
    len[0] = 0; len[1] = 0; pos[0] = 0; pos[1] = 0;

    // reset state held while rst=1
    repeat (3) step(1, 1, 1, "reset");
    #1 rst = 0;

    // ce_tact alone never starts a frame
    repeat (10) half(0, 0, "idle");

    // directed: A = A5C3 with overrun at 3rd tact, B = F then 0 back-to-back
    din_a = 16'hA5C3; din_b = 16'h000F;
    step(1, 1, 1, "start");
    tr_a = '0; tr_b = '0; nceb = 0; novr = 0;
    tr_a[33] = txd_a; tr_b[15] = txd_b;
    for (int i = 1; i <= 34; i++) begin
      bit sa, sb;
      sa = (i == 3);
      sb = (i == 8);
      if (i == 3) din_a = 16'h1234;   // must not leak into the running frame
      if (i == 8) din_b = 16'h0000;
      half(sa, sb, "dir");
      if (i <= 33) tr_a[33-i] = txd_a;
      if (i <= 15) tr_b[15-i] = txd_b;
      nceb += int'(ceb_a);
      novr += int'(ovr_a);
    end
    chk("A5C3 trace", 64'(tr_a), 64'(34'b10_01_10_01_01_10_01_10_10_10_01_01_01_01_10_10_01));
    chk("A ce_bit count", 64'(nceb), 64'd17);
    chk("A ovr count", 64'(novr), 64'd1);
    chk("B back-to-back trace", 64'(tr_b), 64'(16'b10101010_01010101));

    repeat (3) half(0, 0, "gap");

    // randomized: random words, random starts, din scrambled every period
    for (int f = 0; f < 6; f++) begin
      din_a = 16'($urandom); din_b = 16'($urandom);
      half(1, 1, "rnd");
      for (int i = 0; i < 40; i++) begin
        bit sa, sb;
        sa = ($urandom_range(0, 9) == 0);
        sb = ($urandom_range(0, 5) == 0);
        half(sa, sb, "rnd");
        din_a = 16'($urandom); din_b = 16'($urandom);
      end
    end
    repeat (36) half(0, 0, "drain");

    // reset mid-frame at bit 5 second half: immediate abort, no done
    din_a = 16'($urandom); din_b = 16'($urandom);
    half(1, 1, "pre-rst");
    repeat (11) half(0, 0, "pre-rst");
    #2 rst = 1;
    #1;
    chk("async rst A txd", 64'(txd_a), 64'd0);
    chk("async rst A en_tx", 64'(en_a), 64'd0);
    chk("async rst B txd", 64'(txd_b), 64'd0);
    chk("async rst B en_tx", 64'(en_b), 64'd0);
    step(1, 0, 0, "in-rst");
    #1 rst = 0;
    repeat (4) half(0, 0, "post-rst");
    din_a = 16'($urandom); din_b = 16'($urandom);
    half(1, 1, "restart");
    repeat (36) half(0, 0, "restart");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
